// File: rtl/mc_control_fsm.sv
// Main control sequencer for the multicycle RV32I core: one state per cycle through
// fetch/decode/execute/memory/writeback, driving datapath selects, enables and ALU op.
module mc_control_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       instr_retired,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StLui      = 4'd11
  } state_t;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] w_alu_dec;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_retired;
  logic       w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= state_t'(RESET_STATE);
    end else begin
      r_state <= w_next_state;
    end
  end

  // sub only for R-type (op[5] set); addi never subtracts
  always_comb begin
    w_alu_dec = AluAdd;
    case (funct3)
      3'b000:  w_alu_dec = (op[5] && funct7b5) ? AluSub : AluAdd;
      3'b010:  w_alu_dec = AluSlt;
      3'b110:  w_alu_dec = AluOr;
      3'b111:  w_alu_dec = AluAnd;
      default: w_alu_dec = AluAdd;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_pc_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retired    = 1'b0;
    w_illegal    = 1'b0;
    adr_src      = 1'b0;
    result_src   = 2'b00;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_control  = AluAdd;
    imm_src      = 3'b000;
    unique case (r_state)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        w_ir_write = mem_ready;
        w_pc_write = mem_ready;
        if (mem_ready) w_next_state = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLoad:   w_next_state = StMemAdr;
          OpStore:  begin imm_src = 3'b001; w_next_state = StMemAdr; end
          OpRType:  w_next_state = StExecR;
          OpIType:  w_next_state = StExecI;
          OpBranch: begin imm_src = 3'b010; w_next_state = StBranch; end
          OpJal:    begin imm_src = 3'b100; w_next_state = StJal; end
          OpLui:    begin imm_src = 3'b011; w_next_state = StLui; end
          default:  begin w_illegal = 1'b1; w_next_state = StFetch; end
        endcase
      end
      StMemAdr: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        imm_src      = (op == OpStore) ? 3'b001 : 3'b000;
        w_next_state = (op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (mem_ready) w_next_state = StMemWb;
      end
      StMemWb: begin
        result_src   = 2'b01;
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
        w_next_state = StFetch;
      end
      StMemWrite: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (mem_ready) begin
          w_retired    = 1'b1;
          w_next_state = StFetch;
        end
      end
      StExecR: begin
        alu_src_a    = 2'b10;
        alu_control  = w_alu_dec;
        w_next_state = StAluWb;
      end
      StExecI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_control  = w_alu_dec;
        w_next_state = StAluWb;
      end
      StAluWb: begin
        w_reg_write  = 1'b1;
        w_retired    = 1'b1;
        w_next_state = StFetch;
      end
      StBranch: begin
        alu_src_a    = 2'b10;
        alu_control  = AluSub;
        imm_src      = 3'b010;
        w_retired    = 1'b1;
        w_pc_write   = (funct3 == 3'b000) ? zero : ~zero;
        w_next_state = StFetch;
      end
      StJal: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        imm_src      = 3'b100;
        w_pc_write   = 1'b1;
        w_next_state = StAluWb;
      end
      StLui: begin
        // srcA 11 selects the datapath's zero, so add passes the U immediate through
        alu_src_a    = 2'b11;
        alu_src_b    = 2'b01;
        imm_src      = 3'b011;
        w_next_state = StAluWb;
      end
      default: w_next_state = StFetch;
    endcase
  end

  // Enables are masked by rst_n so an in-flight strobe drops the instant reset asserts
  assign pc_write      = w_pc_write & rst_n;
  assign mem_write     = w_mem_write & rst_n;
  assign ir_write      = w_ir_write & rst_n;
  assign reg_write     = w_reg_write & rst_n;
  assign instr_retired = w_retired & rst_n;
  assign illegal_op    = w_illegal & rst_n;

endmodule
